alu_cmd_issuer: RTL and testbench

- Upstream feeder for the 4-bit combinational ALU (ops NOT/AND/OR/XOR/ADD/ZERO).
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one command at a time to the ALU from registered operand/op outputs, captures c/co one cycle later, and presents a tagged result with flags on a valid/ready output stream.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_cmd_issuer_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_issuer.sv | 164 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, tag width and FSM states.
package alu_pkg;

   localparam int TAG_W = 4;

   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_RSV0 = 3'b101;
   localparam logic [2:0] OP_RSV1 = 3'b110;
   localparam logic [2:0] OP_ZERO = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic is_reserved(input logic [2:0] op);
      return (op == OP_RSV0) || (op == OP_RSV1);
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands; callers guard push/pop against full/empty.
module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them one at a time on registered ALU inputs and
// returns tagged, flagged results over a valid/ready stream.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_co,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_c,
   output logic             res_co,
   output logic             res_z,
   output logic             res_err,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);

   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam int EW = $bits(entry_t);

   state_t state;
   state_t state_next;

   entry_t fifo_in;
   entry_t fifo_head;
   logic [EW-1:0] fifo_dout;
   logic fifo_full;
   logic fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   logic push;
   logic pop;
   logic capture;
   logic release_res;

   logic [TAG_W-1:0] tag_cnt;
   logic [TAG_W-1:0] flight_tag;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = !fifo_empty || (state != IDLE);

   assign fifo_in   = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: tag_cnt};
   assign fifo_head = entry_t'(fifo_dout);

   cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (fifo_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = EXEC;
         EXEC:    state_next = HOLD;
         HOLD:    if (res_ready) state_next = fifo_empty ? IDLE : EXEC;
         default: state_next = IDLE;
      endcase
   end

   // A pop happens from IDLE, or back-to-back out of HOLD on the handshake edge.
   always_comb begin
      pop         = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state)
         IDLE: pop = !fifo_empty;
         EXEC: capture = 1'b1;
         HOLD: begin
            release_res = res_ready;
            pop         = res_ready && !fifo_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_cnt <= '0;
      end else if (push) begin
         tag_cnt <= tag_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         flight_tag <= '0;
      end else if (pop) begin
         alu_a      <= fifo_head.a;
         alu_b      <= fifo_head.b;
         alu_op     <= fifo_head.op;
         flight_tag <= fifo_head.tag;
      end
   end

   // The registered alu_op is still the in-flight opcode during EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_c     <= '0;
         res_co    <= 1'b0;
         res_z     <= 1'b0;
         res_err   <= 1'b0;
         res_tag   <= '0;
      end else if (capture) begin
         res_valid <= 1'b1;
         res_tag   <= flight_tag;
         if (is_reserved(alu_op)) begin
            res_c   <= '0;
            res_co  <= 1'b0;
            res_z   <= 1'b1;
            res_err <= 1'b1;
         end else begin
            res_c   <= alu_c;
            res_co  <= alu_co;
            res_z   <= (alu_c == '0) && !alu_co;
            res_err <= 1'b0;
         end
      end else if (release_res) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_issuer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic [3:0] alu_c;
   logic       alu_co;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_c;
   logic       res_co;
   logic       res_z;
   logic       res_err;
   logic [3:0] res_tag;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .WIDTH (4),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .alu_co    (alu_co),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_c     (res_c),
      .res_co    (res_co),
      .res_z     (res_z),
      .res_err   (res_err),
      .res_tag   (res_tag),
      .busy      (busy)
   );

   // Reserved opcodes deliberately produce non-zero garbage so forcing is observable.
   always_comb begin
      alu_c  = 4'h0;
      alu_co = 1'b0;
      case (alu_op)
         3'b000:  alu_c = ~alu_a;
         3'b001:  alu_c = alu_a & alu_b;
         3'b010:  alu_c = alu_a | alu_b;
         3'b011:  alu_c = alu_a ^ alu_b;
         3'b100:  {alu_co, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b111:  alu_c = 4'h0;
         default: begin
            alu_c  = 4'hF;
            alu_co = 1'b1;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      check("cmd_ready_at_push", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic ack();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic get_result(input logic [3:0] c, input logic co, input logic z,
                             input logic err, input logic [3:0] tag, output int waited);
      waited = 0;
      while (!res_valid && waited < 20) begin
         tick();
         waited++;
      end
      check("res_valid_timeout", 32'(res_valid), 32'd1);
      check("res_c", 32'(res_c), 32'(c));
      check("res_co", 32'(res_co), 32'(co));
      check("res_z", 32'(res_z), 32'(z));
      check("res_err", 32'(res_err), 32'(err));
      check("res_tag", 32'(res_tag), 32'(tag));
   endtask

   logic [2:0] b_op [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
   logic [3:0] b_a  [5] = '{4'b1111, 4'b0011, 4'b1100, 4'b0111, 4'b0000};
   logic [3:0] b_b  [5] = '{4'b1000, 4'b0100, 4'b1010, 4'b0001, 4'b0000};
   logic [3:0] b_c  [5] = '{4'b1000, 4'b0111, 4'b0110, 4'b1000, 4'b1111};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      logic seen;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_res_tag", 32'(res_tag), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      // Single ADD with exact latency
      push(3'b100, 4'b1110, 4'b0100);
      check("add_busy", 32'(busy), 32'd1);
      check("add_valid_n1", 32'(res_valid), 32'd0);
      tick();
      check("add_alu_a", 32'(alu_a), 32'hE);
      check("add_alu_b", 32'(alu_b), 32'h4);
      check("add_alu_op", 32'(alu_op), 32'd4);
      check("add_valid_n2", 32'(res_valid), 32'd0);
      tick();
      check("add_valid_after_n2", 32'(res_valid), 32'd1);
      get_result(4'b0010, 1'b1, 1'b0, 1'b0, 4'd0, w);
      ack();
      check("add_released", 32'(res_valid), 32'd0);
      check("add_idle_busy", 32'(busy), 32'd0);

      // Burst fill with backpressure, then drain in order at full rate
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(b_op[i], b_a[i], b_b[i]);
      end
      check("burst_full_ready", 32'(cmd_ready), 32'd0);
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         get_result(b_c[i], 1'b0, 1'b0, 1'b0, 4'(i), w);
         if (i > 0) check("burst_gap", 32'(w), 32'd1);
         tick();
      end
      res_ready = 1'b0;
      check("burst_done_valid", 32'(res_valid), 32'd0);
      check("burst_done_busy", 32'(busy), 32'd0);

      // Reserved op followed by a normal op
      do_reset();
      push(3'b101, 4'b1010, 4'b0001);
      push(3'b010, 4'b1010, 4'b0001);
      get_result(4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, w);
      ack();
      get_result(4'b1011, 1'b0, 1'b0, 1'b0, 4'd1, w);
      ack();

      // Zero op and NOT
      push(3'b111, 4'b1001, 4'b0001);
      get_result(4'b0000, 1'b0, 1'b1, 1'b0, 4'd2, w);
      ack();
      push(3'b000, 4'b1110, 4'b0000);
      get_result(4'b0001, 1'b0, 1'b0, 1'b0, 4'd3, w);
      ack();

      // Backpressure stability with a second command queued
      push(3'b100, 4'b0101, 4'b0011);
      push(3'b011, 4'b0001, 4'b0001);
      get_result(4'b1000, 1'b0, 1'b0, 1'b0, 4'd4, w);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_res_c", 32'(res_c), 32'h8);
         check("hold_res_tag", 32'(res_tag), 32'd4);
         check("hold_alu_a", 32'(alu_a), 32'h5);
         check("hold_alu_b", 32'(alu_b), 32'h3);
         check("hold_alu_op", 32'(alu_op), 32'd4);
         check("hold_busy", 32'(busy), 32'd1);
      end
      ack();
      check("pulse_released", 32'(res_valid), 32'd0);
      check("pulse_next_alu_op", 32'(alu_op), 32'd3);
      get_result(4'b0000, 1'b0, 1'b1, 1'b0, 4'd5, w);
      repeat (3) tick();
      check("pulse_single_valid", 32'(res_valid), 32'd1);
      check("pulse_single_tag", 32'(res_tag), 32'd5);
      ack();

      // Asynchronous reset while executing with three commands queued
      do_reset();
      push(3'b100, 4'b0001, 4'b0001);
      push(3'b001, 4'b1111, 4'b1111);
      push(3'b010, 4'b0010, 4'b0100);
      push(3'b011, 4'b0011, 4'b0001);
      push(3'b000, 4'b0101, 4'b0000);
      check("mid_full", 32'(cmd_ready), 32'd0);
      ack();
      check("mid_exec_alu_a", 32'(alu_a), 32'hF);
      check("mid_exec_alu_op", 32'(alu_op), 32'd1);
      check("mid_exec_valid", 32'(res_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_alu_a", 32'(alu_a), 32'd0);
      check("arst_alu_op", 32'(alu_op), 32'd0);
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_res_c", 32'(res_c), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      res_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | res_valid | busy;
      end
      res_ready = 1'b0;
      check("arst_no_result", 32'(seen), 32'd0);
      check("arst_busy_after", 32'(busy), 32'd0);
      push(3'b100, 4'b0010, 4'b0011);
      get_result(4'b0101, 1'b0, 1'b0, 1'b0, 4'd0, w);
      ack();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
